gray_monitor: RTL and testbench
===============================

GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL have port Clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port Gray, input, 3 bits: gray-code count from the upstream 3-bit gray counter.
REQ-004 SHALL have port Overflow, input, 1 bit: upstream sticky overflow flag.
REQ-005 SHALL have port Clear, input, 1 bit: synchronous soft clear, active-high.
REQ-006 SHALL have port Bin, output, 3 bits: registered binary equivalent of the last accepted Gray.
REQ-007 SHALL have port Step, output, 1 bit: one-cycle pulse on each legal +1 advance.
REQ-008 SHALL have port Wrap, output, 1 bit: one-cycle pulse on each legal 7->0 advance.
REQ-009 SHALL have port WrapCount, output, 8 bits: number of wraps seen, saturating.
REQ-010 SHALL have port Error, output, 1 bit: sticky sequence-violation flag.
REQ-011 SHALL have port State, output, 2 bits: FSM state encoding.

Function
REQ-012 SHALL sample Gray and Overflow on every rising Clk edge; there is no enable, and all outputs SHALL be registered and reflect the sample taken at edge k immediately after edge k (1-cycle latency).
REQ-013 SHALL convert gray to binary as b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-014 SHALL hold internal registers PrevGray[2:0] and PrevOvf, both updated on every edge outside Reset and Clear.
REQ-015 SHALL implement FSM states IDLE=2'b00, TRACK=2'b01, ERR=2'b10; 2'b11 SHALL be unreachable and SHALL go to IDLE on the next edge.
REQ-016 In IDLE, the block SHALL load PrevGray<=Gray, load Bin<=bin(Gray), and go to TRACK, with no legality check, Step=0 and Wrap=0.
REQ-017 In TRACK, with Gray==PrevGray: Step=0, Wrap=0, Bin unchanged, and the FSM stays in TRACK.
REQ-018 In TRACK, with bin(Gray)==bin(PrevGray)+1 mod 8 (exactly one bit differs): Step=1 for one cycle, Bin<=bin(Gray), and the FSM stays in TRACK.
REQ-019 In TRACK, a legal advance from 3'b100 to 3'b000 SHALL additionally set Wrap=1 for one cycle and increment WrapCount, which SHALL saturate at 8'hFF.
REQ-020 In TRACK, any other change (two or three bits differ, or a backward step) SHALL set Error=1, move the FSM to ERR, and leave Bin at its last legal value; Step and Wrap SHALL be 0.
REQ-021 In TRACK, an Overflow rising edge (PrevOvf=0, Overflow=1) in a sample that is not a legal wrap SHALL be an error per REQ-020.
REQ-022 In TRACK, a legal wrap with Overflow already 1 (PrevOvf=1) SHALL be legal.
REQ-023 In TRACK, Overflow falling without Reset or Clear SHALL be ignored.
REQ-024 In ERR, Bin, WrapCount and Error=1 SHALL be held and Step=Wrap=0; the FSM SHALL leave ERR only via Reset or Clear.
REQ-025 Clear=1 in any state SHALL force IDLE, Error=0, Step=0, Wrap=0, Bin=0, WrapCount=0, and PrevOvf<=Overflow.
REQ-026 Reset SHALL take priority over Clear.

Reset
REQ-027 On Reset=1 at an edge: State=IDLE, Bin=3'b000, Step=0, Wrap=0, WrapCount=8'h00, Error=0, PrevGray=3'b000, PrevOvf=0.
REQ-028 A Reset asserted mid-sequence or while in ERR SHALL discard all history; the first sample after Reset is taken per REQ-016.
REQ-029 Outputs SHALL power up to the REQ-027 values before the first Reset.

Verification
REQ-030 Reset, then Gray 000,001,011,010,110,111,101,100 one per cycle -> Bin 0..7, Step=1 on seven cycles, Error=0.
REQ-031 Continue with Gray=000 and Overflow=1 -> Wrap=1 and Step=1 for one cycle, WrapCount=1, Bin=0; 300 further legal wraps -> WrapCount=8'hFF.
REQ-032 In TRACK with Gray=001, drive Gray=010 -> Error=1, State=2'b10, Bin stays 1; further legal codes keep Error=1.
REQ-033 In TRACK with Gray=011, drive Overflow 0->1 while Gray is unchanged -> Error=1, State=ERR.
REQ-034 Assert Clear while in ERR -> next cycle State=IDLE, Error=0, WrapCount=0; the following sample (Gray=110) loads Bin=4, Step=0.
REQ-035 Assert Reset and Clear together mid-count -> REQ-027 values; hold Gray unchanged for 3 cycles -> Step=0 throughout.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: watches a 3-bit gray counter, converts it to binary and
// flags single-step advances, 7->0 wraps and any illegal sequence.
module gray_monitor (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Gray,
  input  logic       Overflow,
  input  logic       Clear,
  output logic [2:0] Bin,
  output logic       Step,
  output logic       Wrap,
  output logic [7:0] WrapCount,
  output logic       Error,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERR   = 2'b10,
    BAD   = 2'b11
  } state_t;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it
  function automatic logic [2:0] grayToBin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  // Declaration initialisers give the same values as Reset at power-up
  state_t     stateQ     = IDLE;
  logic [2:0] binQ       = 3'b000;
  logic       stepQ      = 1'b0;
  logic       wrapQ      = 1'b0;
  logic [7:0] wrapCountQ = 8'h00;
  logic       errorQ     = 1'b0;
  logic [2:0] prevGrayQ  = 3'b000;
  logic       prevOvfQ   = 1'b0;

  state_t     stateD;
  logic [2:0] binD;
  logic       stepD;
  logic       wrapD;
  logic [7:0] wrapCountD;
  logic       errorD;
  logic [2:0] prevGrayD;
  logic       prevOvfD;

  logic [2:0] binNow;
  logic [2:0] binPrev;
  logic       legalStep;
  logic       isWrap;
  logic       ovfRise;

  // Classify the current sample relative to the previous one
  always_comb begin
    binNow    = grayToBin(Gray);
    binPrev   = grayToBin(prevGrayQ);
    legalStep = (binNow == (binPrev + 3'd1));
    isWrap    = legalStep && (prevGrayQ == 3'b100) && (Gray == 3'b000);
    ovfRise   = !prevOvfQ && Overflow;
  end

  // Next-state and output decode; Clear overrides every state
  always_comb begin
    stateD     = stateQ;
    binD       = binQ;
    stepD      = 1'b0;
    wrapD      = 1'b0;
    wrapCountD = wrapCountQ;
    errorD     = errorQ;
    prevGrayD  = Gray;
    prevOvfD   = Overflow;

    if (Clear) begin
      stateD     = IDLE;
      binD       = 3'b000;
      wrapCountD = 8'h00;
      errorD     = 1'b0;
      prevGrayD  = 3'b000;
    end else begin
      case (stateQ)
        IDLE: begin
          binD   = binNow;
          stateD = TRACK;
        end
        TRACK: begin
          if (ovfRise && !isWrap) begin
            errorD = 1'b1;
            stateD = ERR;
          end else if (Gray == prevGrayQ) begin
            stateD = TRACK;
          end else if (legalStep) begin
            stepD = 1'b1;
            binD  = binNow;
            if (isWrap) begin
              wrapD = 1'b1;
              if (wrapCountQ != 8'hFF) begin
                wrapCountD = wrapCountQ + 8'd1;
              end
            end
          end else begin
            errorD = 1'b1;
            stateD = ERR;
          end
        end
        ERR: begin
          errorD = 1'b1;
          stateD = ERR;
        end
        default: begin
          stateD = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous Reset taking priority
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ     <= IDLE;
      binQ       <= 3'b000;
      stepQ      <= 1'b0;
      wrapQ      <= 1'b0;
      wrapCountQ <= 8'h00;
      errorQ     <= 1'b0;
      prevGrayQ  <= 3'b000;
      prevOvfQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      binQ       <= binD;
      stepQ      <= stepD;
      wrapQ      <= wrapD;
      wrapCountQ <= wrapCountD;
      errorQ     <= errorD;
      prevGrayQ  <= prevGrayD;
      prevOvfQ   <= prevOvfD;
    end
  end

  assign Bin       = binQ;
  assign Step      = stepQ;
  assign Wrap      = wrapQ;
  assign WrapCount = wrapCountQ;
  assign Error     = errorQ;
  assign State     = stateQ;

endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: table-driven directed vectors, hand sequences for the
// saturation and reset corner cases, then randomized traffic against a model.
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic       Overflow = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] Bin;
  logic       Step;
  logic       Wrap;
  logic [7:0] WrapCount;
  logic       Error;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;

  gray_monitor dut (
    .Clk(Clk), .Reset(Reset), .Gray(Gray), .Overflow(Overflow), .Clear(Clear),
    .Bin(Bin), .Step(Step), .Wrap(Wrap), .WrapCount(WrapCount),
    .Error(Error), .State(State)
  );

  // Free-running 10-unit clock
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] gray;
    logic       ovf;
    logic       clr;
    logic       rst;
    logic [2:0] expBin;
    logic       expStep;
    logic       expWrap;
    logic [7:0] expWc;
    logic       expErr;
    logic [1:0] expState;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic [2:0] g, input logic o, input logic c,
                              input logic r, input logic [2:0] b, input logic s,
                              input logic w, input logic [7:0] wc, input logic e,
                              input logic [1:0] st);
    vec_t v;
    v.gray = g; v.ovf = o; v.clr = c; v.rst = r;
    v.expBin = b; v.expStep = s; v.expWrap = w; v.expWc = wc;
    v.expErr = e; v.expState = st;
    return v;
  endfunction

  function automatic int grayToBinInt(input logic [2:0] g);
    int acc = 0;
    int res = 0;
    for (int i = 2; i >= 0; i--) begin
      acc = acc ^ int'(g[i]);
      res = res + (acc << i);
    end
    return res;
  endfunction

  function automatic logic [2:0] binToGray(input int b);
    logic [2:0] bb;
    bb = b[2:0];
    return bb ^ (bb >> 1);
  endfunction

  // Behavioural model: tracking/fault flags and integer counters
  bit mHaveRef, mFaulted, mStep, mWrap, mPrevOvf;
  int mBin, mWc, mPrevBin;

  task automatic modelStep(input logic [2:0] g, input logic o, input logic c, input logic r);
    int nb;
    int delta;
    bit rise;
    bit wrapHit;
    nb = grayToBinInt(g);
    mStep = 0;
    mWrap = 0;
    if (r) begin
      mHaveRef = 0; mFaulted = 0; mBin = 0; mWc = 0; mPrevBin = 0; mPrevOvf = 0;
    end else if (c) begin
      mHaveRef = 0; mFaulted = 0; mBin = 0; mWc = 0; mPrevBin = 0; mPrevOvf = o;
    end else if (!mHaveRef) begin
      mHaveRef = 1; mBin = nb; mPrevBin = nb; mPrevOvf = o;
    end else if (mFaulted) begin
      mPrevBin = nb; mPrevOvf = o;
    end else begin
      delta = (nb - mPrevBin + 8) % 8;
      rise = !mPrevOvf && o;
      wrapHit = (delta == 1) && (nb == 0);
      if ((rise && !wrapHit) || (delta > 1)) begin
        mFaulted = 1;
      end else if (delta == 1) begin
        mStep = 1;
        mBin = nb;
        if (wrapHit) begin
          mWrap = 1;
          mWc = (mWc < 255) ? mWc + 1 : 255;
        end
      end
      mPrevBin = nb; mPrevOvf = o;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] g, input logic o, input logic c, input logic r);
    Gray = g; Overflow = o; Clear = c; Reset = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] b, input logic s,
                             input logic w, input logic [7:0] wc, input logic e,
                             input logic [1:0] st);
    checks++;
    if ({Bin, Step, Wrap, WrapCount, Error, State} !== {b, s, w, wc, e, st}) begin
      errors++;
      $display("[TB] FAIL %s: got Bin=%0d Step=%0b Wrap=%0b WrapCount=%0d Error=%0b State=%0d, expected Bin=%0d Step=%0b Wrap=%0b WrapCount=%0d Error=%0b State=%0d",
               name, Bin, Step, Wrap, WrapCount, Error, State, b, s, w, wc, e, st);
    end
  endtask

  initial begin
    int wc;
    int rr;
    int nb;
    logic [2:0] g;
    logic o;
    logic c;
    logic r;

    // Power-up values before any Reset
    #1;
    checkOutput("powerup", 3'd0, 0, 0, 8'd0, 0, 2'd0);

    //                 gray    ovf clr rst bin   stp wr wc    err st
    vecs[0]  = mk(3'b000, 0, 0, 1, 3'd0, 0, 0, 8'd0, 0, 2'd0);
    vecs[1]  = mk(3'b000, 0, 0, 0, 3'd0, 0, 0, 8'd0, 0, 2'd1);
    vecs[2]  = mk(3'b001, 0, 0, 0, 3'd1, 1, 0, 8'd0, 0, 2'd1);
    vecs[3]  = mk(3'b011, 0, 0, 0, 3'd2, 1, 0, 8'd0, 0, 2'd1);
    vecs[4]  = mk(3'b010, 0, 0, 0, 3'd3, 1, 0, 8'd0, 0, 2'd1);
    vecs[5]  = mk(3'b110, 0, 0, 0, 3'd4, 1, 0, 8'd0, 0, 2'd1);
    vecs[6]  = mk(3'b111, 0, 0, 0, 3'd5, 1, 0, 8'd0, 0, 2'd1);
    vecs[7]  = mk(3'b101, 0, 0, 0, 3'd6, 1, 0, 8'd0, 0, 2'd1);
    vecs[8]  = mk(3'b100, 0, 0, 0, 3'd7, 1, 0, 8'd0, 0, 2'd1);
    vecs[9]  = mk(3'b000, 1, 0, 0, 3'd0, 1, 1, 8'd1, 0, 2'd1);
    vecs[10] = mk(3'b001, 1, 0, 0, 3'd1, 1, 0, 8'd1, 0, 2'd1);
    vecs[11] = mk(3'b010, 1, 0, 0, 3'd1, 0, 0, 8'd1, 1, 2'd2);
    vecs[12] = mk(3'b110, 1, 0, 0, 3'd1, 0, 0, 8'd1, 1, 2'd2);
    vecs[13] = mk(3'b111, 1, 0, 0, 3'd1, 0, 0, 8'd1, 1, 2'd2);
    vecs[14] = mk(3'b111, 1, 1, 0, 3'd0, 0, 0, 8'd0, 0, 2'd0);
    vecs[15] = mk(3'b110, 1, 0, 0, 3'd4, 0, 0, 8'd0, 0, 2'd1);
    vecs[16] = mk(3'b000, 0, 0, 1, 3'd0, 0, 0, 8'd0, 0, 2'd0);
    vecs[17] = mk(3'b001, 0, 0, 0, 3'd1, 0, 0, 8'd0, 0, 2'd1);
    vecs[18] = mk(3'b011, 0, 0, 0, 3'd2, 1, 0, 8'd0, 0, 2'd1);
    vecs[19] = mk(3'b011, 1, 0, 0, 3'd2, 0, 0, 8'd0, 1, 2'd2);
    vecs[20] = mk(3'b011, 1, 1, 0, 3'd0, 0, 0, 8'd0, 0, 2'd0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].gray, vecs[i].ovf, vecs[i].clr, vecs[i].rst);
      checkOutput($sformatf("vec%0d", i), vecs[i].expBin, vecs[i].expStep,
                  vecs[i].expWrap, vecs[i].expWc, vecs[i].expErr, vecs[i].expState);
    end

    // Saturation: 300 full laps after a reset, WrapCount must stop at 255
    applyStimulus(3'b000, 0, 0, 1);
    applyStimulus(3'b000, 0, 0, 0);
    wc = 0;
    for (int lap = 0; lap < 300; lap++) begin
      for (int b = 1; b <= 8; b++) begin
        applyStimulus(binToGray(b % 8), 0, 0, 0);
      end
      wc = (wc < 255) ? wc + 1 : 255;
      if (lap < 3 || lap > 252) begin
        checkOutput($sformatf("wrap%0d", lap), 3'd0, 1, 1, wc[7:0], 0, 2'd1);
      end
    end
    checkOutput("wrapSat", 3'd0, 1, 1, 8'hFF, 0, 2'd1);

    // Reset and Clear together mid-count, then a held code yields no Step
    applyStimulus(3'b001, 0, 0, 0);
    applyStimulus(3'b011, 0, 0, 0);
    applyStimulus(3'b011, 0, 1, 1);
    checkOutput("rstClr", 3'd0, 0, 0, 8'd0, 0, 2'd0);
    applyStimulus(3'b010, 0, 0, 0);
    checkOutput("hold0", 3'd3, 0, 0, 8'd0, 0, 2'd1);
    applyStimulus(3'b010, 0, 0, 0);
    checkOutput("hold1", 3'd3, 0, 0, 8'd0, 0, 2'd1);
    applyStimulus(3'b010, 0, 0, 0);
    checkOutput("hold2", 3'd3, 0, 0, 8'd0, 0, 2'd1);

    // Randomized traffic compared against the model every cycle
    applyStimulus(3'b000, 0, 0, 1);
    modelStep(3'b000, 0, 0, 1);
    o = 0;
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 15);
      if (rr <= 2)       nb = mPrevBin;
      else if (rr <= 12) nb = mPrevBin + 1;
      else if (rr == 13) nb = mPrevBin + 2;
      else if (rr == 14) nb = mPrevBin + 7;
      else               nb = $urandom_range(0, 7);
      g = binToGray(nb % 8);
      if ($urandom_range(0, 19) == 0) o = ~o;
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(g, o, c, r);
      modelStep(g, o, c, r);
      checkOutput($sformatf("rand%0d", n), mBin[2:0], mStep, mWrap, mWc[7:0], mFaulted,
                  mFaulted ? 2'd2 : (mHaveRef ? 2'd1 : 2'd0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
